// File: rtl/rr_arbiter_8way.sv
// rr_arbiter_8way: round-robin owner arbiter for 8 requesters with release, drop and hold-limit handoff.
module rr_arbiter_8way #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       busy,
  output logic       timeout
);
  typedef enum logic {IDLE, OWNED} state_t;
  localparam logic [CNT_W-1:0] hold_cap = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       ptr, ptr_n, id_n, base, idx, win;
  logic [7:0]       cand;
  logic             found, drop, lim, ending, timeout_n;
  always_comb begin
    base = (state == OWNED) ? grant_id + 3'd1 : ptr;
    cand = (state == OWNED) ? req & ~(8'd1 << grant_id) : req;
    found = 1'b0;
    win = '0;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      idx = base + 3'(i);
      if (!found && cand[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  always_comb begin
    drop = !req[grant_id];
    lim = (MAX_HOLD != 0) && (cnt == hold_cap);
    ending = rel || drop || lim;
    state_n = state;
    cnt_n = cnt;
    ptr_n = ptr;
    id_n = grant_id;
    timeout_n = 1'b0;
    if (state == IDLE) begin
      if (found) begin
        state_n = OWNED;
        id_n = win;
        cnt_n = CNT_W'(1);
      end
    end else if (!ending) begin
      cnt_n = (cnt == hold_cap) ? cnt : cnt + CNT_W'(1);
    end else begin
      ptr_n = grant_id + 3'd1;
      timeout_n = lim && !rel && !drop;
      // a timed-out owner is excluded by the mask and never re-granted in the same edge
      if (found) begin
        id_n = win;
        cnt_n = CNT_W'(1);
      end else if (rel && req[grant_id]) begin
        cnt_n = CNT_W'(1);
      end else begin
        state_n = IDLE;
        id_n = '0;
        cnt_n = '0;
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ptr <= '0;
      grant <= '0;
      grant_id <= '0;
      busy <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ptr <= ptr_n;
      grant <= (state_n == OWNED) ? 8'd1 << id_n : 8'd0;
      grant_id <= id_n;
      busy <= state_n == OWNED;
      timeout <= timeout_n;
    end
  end
endmodule

// File: tb/tb_rr_arbiter_8way.sv
// tb_rr_arbiter_8way: directed scoreboard bench for the round-robin owner arbiter (hold limit 4).
module tb_rr_arbiter_8way;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] req = 8'hFF;
  logic       rel = 1'b0;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       busy;
  logic       timeout;
  int passed = 0;
  int total = 0;
  int fails = 0;
  typedef struct {
    logic [7:0] g;
    logic [2:0] id;
    logic       b;
    logic       t;
  } exp_t;
  exp_t q[$];

  rr_arbiter_8way #(.MAX_HOLD(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .req(req), .rel(rel),
    .grant(grant), .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input exp_t e);
    check({tag, ".grant"}, grant, e.g);
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, e.b});
    check({tag, ".timeout"}, {7'd0, timeout}, {7'd0, e.t});
    if (e.b) check({tag, ".grant_id"}, {5'd0, grant_id}, {5'd0, e.id});
    else check({tag, ".grant_id"}, {5'd0, grant_id}, 8'd0);
  endtask

  task automatic step(input string tag, input logic [7:0] r, input logic rl,
                      input logic [7:0] g, input logic [2:0] id, input logic t);
    exp_t e;
    req = r;
    rel = rl;
    q.push_back('{g: g, id: id, b: (g != 8'd0), t: t});
    @(posedge clk);
    #1;
    e = q.pop_front();
    check_all(tag, e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    rel = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    @(posedge clk);
    #1;
    check_all("reset", '{g: 8'h00, id: 3'd0, b: 1'b0, t: 1'b0});
    reset = 1'b0;
    // full rotation under release pulses
    step("rot0", 8'hFF, 1'b0, 8'h01, 3'd0, 1'b0);
    for (int i = 1; i <= 8; i++)
      step("rot", 8'hFF, 1'b1, 8'(8'd1 << (i % 8)), 3'(i % 8), 1'b0);
    // sparse requests with wrap-around
    do_reset();
    step("sparse0", 8'h84, 1'b0, 8'h04, 3'd2, 1'b0);
    step("sparse1", 8'h84, 1'b1, 8'h80, 3'd7, 1'b0);
    step("sparse2", 8'h84, 1'b1, 8'h04, 3'd2, 1'b0);
    // single requester released before the limit keeps its grant
    do_reset();
    step("single0", 8'h10, 1'b0, 8'h10, 3'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step("single_hold", 8'h10, 1'b0, 8'h10, 3'd4, 1'b0);
      step("single_hold", 8'h10, 1'b0, 8'h10, 3'd4, 1'b0);
      step("single_rel", 8'h10, 1'b1, 8'h10, 3'd4, 1'b0);
    end
    // hold limit hands off to the next requester
    do_reset();
    step("lim0", 8'h03, 1'b0, 8'h01, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) step("lim_hold", 8'h03, 1'b0, 8'h01, 3'd0, 1'b0);
    step("lim_move", 8'h03, 1'b0, 8'h02, 3'd1, 1'b1);
    step("lim_after", 8'h03, 1'b0, 8'h02, 3'd1, 1'b0);
    // hold limit with a lone requester forces an idle cycle
    do_reset();
    step("lone0", 8'h01, 1'b0, 8'h01, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) step("lone_hold", 8'h01, 1'b0, 8'h01, 3'd0, 1'b0);
    step("lone_idle", 8'h01, 1'b0, 8'h00, 3'd0, 1'b1);
    step("lone_regrant", 8'h01, 1'b0, 8'h01, 3'd0, 1'b0);
    // owner drops its request; non-owner churn does not disturb
    do_reset();
    step("drop0", 8'h20, 1'b0, 8'h20, 3'd5, 1'b0);
    step("drop1", 8'h40, 1'b0, 8'h40, 3'd6, 1'b0);
    step("churn", 8'h43, 1'b0, 8'h40, 3'd6, 1'b0);
    // release while idle is ignored
    do_reset();
    step("idle_rel", 8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
    // asynchronous reset between edges
    step("async0", 8'h08, 1'b0, 8'h08, 3'd3, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    check_all("async_rst", '{g: 8'h00, id: 3'd0, b: 1'b0, t: 1'b0});
    req = 8'h80;
    #2;
    reset = 1'b0;
    step("async_after", 8'h80, 1'b0, 8'h80, 3'd7, 1'b0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_8way.md
Name: rr_arbiter_8way

Overview:
- Round-robin arbiter that shares one 8-input resource slot among 8 requesters.
- Grants exclusive ownership to one requester at a time. The owner holds the grant until it releases, drops its request, or exceeds a hold limit.
- Sits in front of the 8-way gate datapath blocks and sequences which source drives the shared resource.
- Fairness: the search pointer rotates to the slot after the last owner.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may hold the grant. 0 disables the limit.
- CNT_W, 5, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  8  request lines; req[i] high means requester i wants the resource.
- release  input  1  owner pulses high for one cycle to give up the grant.
- grant  output  8  registered one-hot grant vector; all zero when idle.
- grant_id  output  3  registered index of the current owner; valid only when busy=1.
- busy  output  1  registered; high while any grant is held.
- timeout  output  1  registered one-cycle pulse when a grant is forcibly revoked by MAX_HOLD.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - Forces grant=0, grant_id=0, busy=0, timeout=0, hold counter=0, pointer ptr=0, state=IDLE.
  - Takes effect immediately, without waiting for a clk edge.
  - Reset mid-grant drops the grant in the same instant.
- State machine has two states: IDLE and OWNED.
- Selection function: scan indices ptr, ptr+1, ..., ptr+7, all modulo 8. The first index with req set wins.
- IDLE:
  - On a clk edge with req != 0: grant[win]=1, grant_id=win, busy=1, counter=1, go to OWNED.
  - Latency: a request sampled at edge N is granted at edge N. The grant is visible for the cycle after edge N.
  - req == 0: stay in IDLE with all outputs zero.
- OWNED, end condition E: release=1, OR req[grant_id]=0, OR (MAX_HOLD != 0 AND counter == MAX_HOLD).
- OWNED, E false: hold grant and increment counter. The counter saturates at MAX_HOLD.
- OWNED, E true at an edge:
  - ptr <= grant_id+1 (mod 8; 7 wraps to 0).
  - Re-arbitrate in the same edge using the new ptr and the current req, with bit grant_id masked out.
  - If another requester wins: grant moves to it back-to-back with no idle cycle, and counter=1.
  - If none wins, but req[grant_id] is still high and the end cause was release: the same owner is re-granted with counter=1.
  - If the end cause was timeout, the old owner is never re-granted in that edge. Go to IDLE with grant=0 and busy=0.
  - Otherwise go to IDLE with grant=0 and busy=0.
- timeout:
  - Is 1 for exactly the cycle after an edge where the counter limit caused E.
  - If release or a dropped request occurs in the same cycle as the limit, those take priority and timeout stays 0.
- Invariants:
  - grant is always zero or one-hot.
  - busy == |grant.
  - grant_id equals the set bit position of grant.
- A release pulse while in IDLE is ignored.
- req changes on non-owner lines never disturb the current grant.

Test Plan:
- Reset with req=8'hFF, then release reset: edge 1 gives grant=8'h01, grant_id=0. Owner 0 pulses release: next edge gives grant=8'h02, ptr=1. Continuing releases cycle grants 02→04→…→80→01.
- Sparse requests, req=8'b1000_0100, ptr=0: grant=8'h04. After release, grant=8'h80. After the next release, wrap-around gives grant=8'h04.
- Single requester: req=8'h10 held high with periodic release pulses → grant stays 8'h10, busy never drops, timeout=0 while releases arrive within 16 cycles.
- Hold limit, MAX_HOLD=4, req=8'h03, no release: owner 0 holds 4 cycles, then timeout pulses 1 cycle and grant moves to 8'h02. Same test with req=8'h01: grant goes to 0 for at least one cycle and busy=0 before the re-grant.
- Owner drops request: grant=8'h20, req[5] goes 0, req[6]=1 → next edge grant=8'h40, timeout=0.
- Asynchronous reset asserted mid-grant, between clock edges: grant, busy and grant_id go to 0 immediately. After deassert with req=8'h80, the first edge grants 8'h80 (ptr=0 scan).
